// File: rtl/mips_pkg.sv
// Shared MIPS debug definitions: default register-file geometry and the
// encodings of the register-dump FSM states.
package mips_pkg;

  localparam int DEFAULT_DEPTH      = 5;
  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [2:0] ST_IDLE_ENC = 3'd0;
  localparam logic [2:0] ST_READ_ENC = 3'd1;
  localparam logic [2:0] ST_HOLD_ENC = 3'd2;
  localparam logic [2:0] ST_SUM_ENC  = 3'd3;
  localparam logic [2:0] ST_DONE_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_READ = ST_READ_ENC,
    ST_HOLD = ST_HOLD_ENC,
    ST_SUM  = ST_SUM_ENC,
    ST_DONE = ST_DONE_ENC
  } dump_state_e;

endpackage

// File: rtl/reg_file_dump_reader_if.sv
// Register-file read port plus the valid/ready dump stream. The reader is the
// master; the register file and stream sink together form the slave side.
interface reg_file_dump_reader_if
  import mips_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DEPTH-1:0]      rf_addr;
  logic [DATA_WIDTH-1:0] rf_rdata;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [DEPTH-1:0]      dout_addr;
  logic [DATA_WIDTH-1:0] dout_data;
  logic                  dout_last;

  modport master (
    output rf_addr,
    input  rf_rdata,
    output dout_valid,
    input  dout_ready,
    output dout_addr,
    output dout_data,
    output dout_last
  );

  modport slave (
    input  rf_addr,
    output rf_rdata,
    input  dout_valid,
    output dout_ready,
    input  dout_addr,
    input  dout_data,
    input  dout_last
  );

endinterface

// File: rtl/reg_file_dump_reader.sv
// Debug-side register-file dumper: walks first..last (inclusive, wrapping) and
// streams each word out. Define REG_DUMP_CHECKSUM_EN to append an XOR checksum beat.
module reg_file_dump_reader
  import mips_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [DEPTH-1:0]              first_addr,
  input  logic [DEPTH-1:0]              last_addr,
  reg_file_dump_reader_if.master        bus,
  output logic                          busy,
  output logic                          done
);

  dump_state_e           state_q, state_d;
  logic [DEPTH-1:0]      ptr_q, ptr_d;
  logic [DEPTH-1:0]      last_q, last_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  dout_last_q, dout_last_d;
  logic [DEPTH-1:0]      dout_addr_q, dout_addr_d;
  logic [DATA_WIDTH-1:0] dout_data_q, dout_data_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic                  reg_last_q, reg_last_d;
`endif

  // NOTE: every variable gets its hold value before the case statement, so no
  // path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    last_d       = last_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    dout_addr_d  = dout_addr_q;
    dout_data_d  = dout_data_q;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d       = csum_q;
    reg_last_d   = reg_last_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          ptr_d   = first_addr;
          last_d  = last_addr;
          state_d = ST_READ;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      ST_READ: begin
        if (abort) begin
          state_d      = ST_IDLE;
          dout_valid_d = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d       = '0;
`endif
        end else begin
          dout_data_d  = bus.rf_rdata;
          dout_addr_d  = ptr_q;
          dout_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          dout_last_d  = 1'b0;
          reg_last_d   = (ptr_q == last_q);
          csum_d       = csum_q ^ bus.rf_rdata;
`else
          dout_last_d  = (ptr_q == last_q);
`endif
          state_d      = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (abort) begin
          state_d      = ST_IDLE;
          dout_valid_d = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d       = '0;
`endif
        end else if (dout_valid_q && bus.dout_ready) begin
          dout_valid_d = 1'b0;
          if (dout_last_q) begin
            state_d = ST_DONE;
`ifdef REG_DUMP_CHECKSUM_EN
          end else if (reg_last_q) begin
            state_d = ST_SUM;
`endif
          end else begin
            ptr_d   = ptr_q + 1'b1;  // wraps mod 2**DEPTH
            state_d = ST_READ;
          end
        end
      end

`ifdef REG_DUMP_CHECKSUM_EN
      ST_SUM: begin
        if (abort) begin
          state_d      = ST_IDLE;
          dout_valid_d = 1'b0;
          csum_d       = '0;
        end else begin
          dout_data_d  = csum_q;
          dout_addr_d  = '0;
          dout_last_d  = 1'b1;
          dout_valid_d = 1'b1;
          reg_last_d   = 1'b0;
          state_d      = ST_HOLD;
        end
      end
`endif

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      last_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_addr_q  <= '0;
      dout_data_q  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q       <= '0;
      reg_last_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_q       <= last_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_addr_q  <= dout_addr_d;
      dout_data_q  <= dout_data_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q       <= csum_d;
      reg_last_q   <= reg_last_d;
`endif
    end
  end

  assign bus.rf_addr    = (state_q == ST_IDLE) ? '0 : ptr_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.dout_addr  = dout_addr_q;
  assign bus.dout_data  = dout_data_q;
  assign busy           = (state_q != ST_IDLE);
  // An abort landing on the DONE cycle suppresses the completion pulse.
  assign done           = (state_q == ST_DONE) && !abort;

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// Directed self-checking bench for reg_file_dump_reader: full, wrapped and
// single-word dumps, back-pressure, abort, ignored start and async reset.
module tb_reg_file_dump_reader;
  import mips_pkg::*;

  localparam int DEPTH = 5;
  localparam int DW    = 32;
  localparam int NREGS = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [DEPTH-1:0] first_addr = '0;
  logic [DEPTH-1:0] last_addr = '0;
  logic             busy;
  logic             done;
  logic [DW-1:0]    regs [NREGS];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_dump_reader_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

  assign bus.rf_rdata = regs[bus.rf_addr];

  reg_file_dump_reader #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one dump f..l with the sink always ready; checks every beat against
  // the register array. poke_at >= 0 pulses a bogus start on that cycle.
  task automatic run_dump(input string name, input logic [DEPTH-1:0] f,
                          input logic [DEPTH-1:0] l, input int poke_at);
    int n;
    int total;
    int k;
    int last_hs;
    bit seen_done;
    logic [DEPTH-1:0] ea;
    logic [DW-1:0] ed;
    logic el;
    logic [DW-1:0] x;
    n = ((int'(l) - int'(f) + NREGS) % NREGS) + 1;
`ifdef REG_DUMP_CHECKSUM_EN
    total = n + 1;
`else
    total = n;
`endif
    k = 0;
    last_hs = -10;
    seen_done = 1'b0;
    x = '0;
    bus.dout_ready = 1'b1;
    start = 1'b1;
    first_addr = f;
    last_addr = l;
    tick();
    start = 1'b0;
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    check({name, "_rf_addr_first"}, 32'(bus.rf_addr), 32'(f));
    for (int cyc = 0; cyc < 300; cyc++) begin
      tick();
      if (cyc == 0) check({name, "_first_valid_latency"}, 32'(bus.dout_valid), 32'd1);
      if (done) begin
        check({name, "_done_timing"}, 32'(cyc), 32'(last_hs + 1));
        seen_done = 1'b1;
        break;
      end
      if (bus.dout_valid && bus.dout_ready) begin
        if (k < n) begin
          ea = f + DEPTH'(k);
          ed = regs[ea];
`ifdef REG_DUMP_CHECKSUM_EN
          el = 1'b0;
`else
          el = (k == n - 1);
`endif
          x = x ^ ed;
        end else begin
          ea = '0;
          ed = x;
          el = 1'b1;
        end
        check($sformatf("%s_beat%0d_addr", name, k), 32'(bus.dout_addr), 32'(ea));
        check($sformatf("%s_beat%0d_data", name, k), bus.dout_data, ed);
        check($sformatf("%s_beat%0d_last", name, k), 32'(bus.dout_last), 32'(el));
        k++;
        last_hs = cyc;
      end
      start = (cyc == poke_at);
      if (cyc == poke_at) begin
        first_addr = '0;
        last_addr = '0;
      end
    end
    start = 1'b0;
    check({name, "_beat_count"}, 32'(k), 32'(total));
    check({name, "_done_seen"}, 32'(seen_done), 32'd1);
    tick();
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit found;
    bus.dout_ready = 1'b1;
    for (int i = 0; i < NREGS; i++) regs[i] = 32'(i) * 32'h1111_1111;

    // Reset state
    repeat (2) tick();
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_last", 32'(bus.dout_last), 32'd0);
    check("rst_addr", 32'(bus.dout_addr), 32'd0);
    check("rst_data", bus.dout_data, 32'd0);
    check("rst_rf_addr", 32'(bus.rf_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: full range
    run_dump("full", 5'd0, 5'd31, -1);

    // 2: wrap-around
    run_dump("wrap", 5'd29, 5'd2, -1);

    // 3: single beat under back-pressure; a later register write must not leak in
    bus.dout_ready = 1'b0;
    start = 1'b1;
    first_addr = 5'd7;
    last_addr = 5'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10 && !bus.dout_valid; i++) tick();
    check("bp_valid_seen", 32'(bus.dout_valid), 32'd1);
    regs[7] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold%0d_valid", i), 32'(bus.dout_valid), 32'd1);
      check($sformatf("bp_hold%0d_addr", i), 32'(bus.dout_addr), 32'd7);
      check($sformatf("bp_hold%0d_data", i), bus.dout_data, 32'h7777_7777);
      check($sformatf("bp_hold%0d_last", i), 32'(bus.dout_last), 32'd1);
      check($sformatf("bp_hold%0d_done", i), 32'(done), 32'd0);
    end
    bus.dout_ready = 1'b1;
    tick();
    check("bp_done", 32'(done), 32'd1);
    check("bp_valid_dropped", 32'(bus.dout_valid), 32'd0);
    tick();
    check("bp_done_cleared", 32'(done), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);
    regs[7] = 32'h7777_7777;

    // 4: abort while beat 3 is held
    start = 1'b1;
    first_addr = 5'd0;
    last_addr = 5'd31;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.dout_valid && bus.dout_addr == 5'd3) begin
        abort = 1'b1;
        bus.dout_ready = 1'b0;
        found = 1'b1;
        break;
      end
    end
    check("abort_beat3_reached", 32'(found), 32'd1);
    tick();
    abort = 1'b0;
    check("abort_valid", 32'(bus.dout_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_no_done%0d", i), 32'(done), 32'd0);
    end
    run_dump("post_abort", 5'd5, 5'd6, -1);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    first_addr = 5'd1;
    last_addr = 5'd4;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    tick();
    check("start_abort_valid", 32'(bus.dout_valid), 32'd0);

    // 5a: start while busy is ignored
    run_dump("busy_start", 5'd10, 5'd12, 1);

    // 5b: asynchronous reset mid-dump
    start = 1'b1;
    first_addr = 5'd0;
    last_addr = 5'd31;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.dout_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_addr", 32'(bus.dout_addr), 32'd0);
    check("arst_data", bus.dout_data, 32'd0);
    check("arst_last", 32'(bus.dout_last), 32'd0);
    check("arst_rf_addr", 32'(bus.rf_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_stays_idle", 32'(busy), 32'd0);
    check("arst_no_done", 32'(done), 32'd0);

    // single-word range after reset
    run_dump("single", 5'd0, 5'd0, -1);

`ifdef REG_DUMP_CHECKSUM_EN
    // 6: checksum beat, 0xA5 ^ 0x0F ^ 0xF0 = 0x5A
    regs[1] = 32'h0000_00A5;
    regs[2] = 32'h0000_000F;
    regs[3] = 32'h0000_00F0;
    run_dump("csum", 5'd1, 5'd3, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
